spi_mem_responder: RTL and testbench
====================================

# spi_mem_responder

SPI-mode-0 responder that models the external flash/RAM device on the far end of the MCU's SPI memory initiator. It decodes the initiator's 8-bit command and 24-bit address header, then returns read bytes on `miso` or stores write bytes into an internal byte array. It runs from its own faster system clock and oversamples the SPI pins. It serves as the synthesizable memory target in the FPGA/test harness and as the bench partner for the initiator.

## Interface

Parameters:
- `ADDR_BITS`, 8: number of address LSBs used; array depth = 2^ADDR_BITS bytes.
- `CMD_READ`, 8'h03: read command code.
- `CMD_WRITE`, 8'h02: write command code.

Ports:
- `clk`  input  1  system clock; single clock domain.
- `rst`  input  1  reset, synchronous, active-high.
- `sclk`  input  1  SPI clock from the initiator; asynchronous to `clk`.
- `cs_n`  input  1  chip select, active-low; asynchronous.
- `mosi`  input  1  initiator data, MSB first; asynchronous.
- `miso`  output  1  responder data, MSB first.
- `miso_oe`  output  1  high while `miso` is actively driven (READ data phase).
- `busy`  output  1  high from detected `cs_n` fall to detected `cs_n` rise.
- `wr_strobe`  output  1  one-`clk` pulse per byte committed to the array.
- `wr_addr`  output  ADDR_BITS  address of the committed byte (valid with `wr_strobe`).
- `wr_data`  output  8  committed byte (valid with `wr_strobe`).

## Operation

- `sclk`, `cs_n`, `mosi` each pass through a 2-flop synchronizer. A third flop on `sclk` and `cs_n` provides rise/fall detection. All logic acts on the synchronized signals.
- States:
  - IDLE: waiting for a transaction.
  - HDR: receiving the 32-bit header.
  - READ: read data phase.
  - WRITE: write data phase.
  - IGNORE: discarding an unrecognized transaction.
- IDLE -> HDR on detected `cs_n` fall. Clears the 6-bit bit counter and the header shift register, and sets `busy`.
- HDR, on each sclk rise: shift `mosi` into the 32-bit header register. After the 32nd bit, branch on header[31:24]:
  - `CMD_READ` -> READ
  - `CMD_WRITE` -> WRITE
  - any other value -> IGNORE
- The address pointer loads from header[ADDR_BITS-1:0]. Header bits [23:ADDR_BITS] are ignored.
- READ:
  - On the first sclk fall after entry, load `mem[ptr]` into the tx shift register, drive bit 7 on `miso`, and raise `miso_oe`.
  - Each later sclk fall shifts out the next bit.
  - After 8 bits, the next fall loads `mem[ptr+1]`.
  - The pointer increments modulo 2^ADDR_BITS (wraps 0xFF -> 0x00 at the default).
  - Reads continue for as long as `cs_n` stays low.
- WRITE:
  - On each sclk rise, shift `mosi` into the rx byte register.
  - On the 8th bit, write `mem[ptr]`, pulse `wr_strobe` with `wr_addr`=ptr and `wr_data`=byte, then increment ptr with the same wrap.
- IGNORE: no array access; `miso`=0 and `miso_oe`=0 until `cs_n` rises.
- A detected `cs_n` rise in any state returns to IDLE next `clk`:
  - `miso`=0, `miso_oe`=0, `busy`=0.
  - A partial header is dropped.
  - A partial write byte (<8 bits) is discarded and never written.
- sclk edges while `cs_n` is high are ignored.
- Reset values: `miso`=0, `miso_oe`=0, `busy`=0, `wr_strobe`=0, `wr_addr`=0, `wr_data`=0, state IDLE.
- The array contents are not cleared by `rst`.
- `rst` mid-transaction aborts it immediately. The responder stays in IDLE until a fresh `cs_n` fall; a `cs_n` that is already low does not restart it.

## Timing

- Pin-to-detect latency: 3 `clk` cycles from an sclk/cs_n pin edge to the internal edge pulse.
- `miso` updates 3–4 `clk` after the sclk falling pin edge.
- Requirement: the sclk high and low phases each last ≥ 6 `clk` cycles, so `miso` settles before the initiator samples on the next rising edge. The bench enforces this ratio; the block does not check it.
- The first read-data bit is valid before the 33rd sclk rise. This matches an initiator that samples `miso` on every rising edge, including header bits.
- `wr_strobe` asserts 1 `clk` after the 8th-bit sclk rise is detected and lasts exactly 1 `clk`.
- Array read is combinational from ptr into the tx load; the array write is synchronous on `clk`.
- Simultaneous `cs_n` rise and sclk edge detection: `cs_n` wins and the sclk edge is dropped.

## Test plan

- Write/readback:
  - Stimulus: `cs_n` low, send 02 000010 AA BB CC DD, `cs_n` high.
  - Required: four `wr_strobe` pulses at addresses 0x10–0x13 with data AA, BB, CC, DD.
  - Then send 03 000010 with 32 read clocks: `miso` returns AABBCCDD, and `miso_oe` is high only during the data clocks.
- Wrap:
  - Stimulus: write 11 22 starting at address 0x0000FF.
  - Required: strobes at addresses 0xFF and 0x00.
  - Reading 3 bytes from 0xFF returns 11 22 followed by the previous content at address 0x01.
- Partial byte abort:
  - Stimulus: send 02 000020 followed by 5 bits, then raise `cs_n`.
  - Required: no `wr_strobe`; address 0x20 is unchanged on readback.
- Unknown command:
  - Stimulus: send 9F 000000 with 16 more clocks.
  - Required: `miso`=0, `miso_oe`=0, no strobes; `busy` falls 3–4 `clk` after `cs_n` rises.
- Reset mid-read:
  - Stimulus: pulse `rst` for 1 `clk` during the read data phase while `cs_n` stays low.
  - Required: `miso`, `miso_oe` and `busy` are 0 on the next `clk`, and remain 0 through further sclk toggles until `cs_n` goes high then low again.
- Back-to-back transactions:
  - Stimulus: `cs_n` high for only 8 `clk` between a write of 0x5A to address 0x40 and a read from 0x40.
  - Required: the read returns 0x5A.

Source files
------------

// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 memory target with READ/WRITE commands on oversampled pins
module spi_mem_responder #(
   parameter int         ADDR_BITS = 8,
   parameter logic [7:0] CMD_READ  = 8'h03,
   parameter logic [7:0] CMD_WRITE = 8'h02
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic                 busy,
   output logic                 wr_strobe,
   output logic [ADDR_BITS-1:0] wr_addr,
   output logic [7:0]           wr_data
);
   typedef enum logic [2:0] {IDLE, HDR, READ, WRITE, IGNORE} state_t;
   state_t state, state_nx;
   logic [2:0] sclk_s, cs_s;
   logic [1:0] mosi_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall, hdr_done, wr_fire, rd_step;
   logic [5:0] bit_cnt;
   logic [30:0] hdr;
   logic [31:0] hdr_nx;
   logic [6:0] rx;
   logic [7:0] rx_nx, tx;
   logic [ADDR_BITS-1:0] ptr;
   logic [7:0] mem [2**ADDR_BITS];

   // pin synchronizers, left unreset so a cs_n held low across rst yields no fresh fall
   always_ff @(posedge clk) begin
      sclk_s <= {sclk_s[1:0], sclk};
      cs_s <= {cs_s[1:0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
   end

   assign sclk_rise = sclk_s[1] & ~sclk_s[2];
   assign sclk_fall = ~sclk_s[1] & sclk_s[2];
   assign cs_rise = cs_s[1] & ~cs_s[2];
   assign cs_fall = ~cs_s[1] & cs_s[2];
   assign hdr_nx = {hdr, mosi_s[1]};
   assign rx_nx = {rx, mosi_s[1]};
   assign hdr_done = state == HDR && sclk_rise && !cs_rise && bit_cnt == 6'd31;
   assign wr_fire = state == WRITE && sclk_rise && !cs_rise && bit_cnt[2:0] == 3'd7;
   assign rd_step = state == READ && sclk_fall && !cs_rise;
   assign miso = miso_oe & tx[7];

   // state register
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;

   // next state: cs_n rise aborts from anywhere, header completion dispatches on the command byte
   always_comb begin
      state_nx = state;
      if (cs_rise)
         state_nx = IDLE;
      else if (state == IDLE && cs_fall)
         state_nx = HDR;
      else if (hdr_done)
         state_nx = hdr_nx[31:24] == CMD_READ ? READ : hdr_nx[31:24] == CMD_WRITE ? WRITE : IGNORE;
   end

   // byte array write port
   always_ff @(posedge clk)
      if (wr_fire && !rst) mem[ptr] <= rx_nx;

   // header capture, shift registers, pointer and handshake outputs
   always_ff @(posedge clk) begin
      wr_strobe <= 1'b0;
      if (rst) begin
         miso_oe <= 1'b0;
         busy <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else if (cs_rise) begin
         miso_oe <= 1'b0;
         busy <= 1'b0;
      end else begin
         if (state == IDLE && cs_fall) begin
            bit_cnt <= '0;
            hdr <= '0;
            busy <= 1'b1;
         end
         if (state == HDR && sclk_rise) begin
            hdr <= hdr_nx[30:0];
            bit_cnt <= hdr_done ? 6'd0 : bit_cnt + 6'd1;
         end
         if (hdr_done) ptr <= hdr_nx[ADDR_BITS-1:0];
         if (rd_step) begin
            tx <= bit_cnt[2:0] == 3'd0 ? mem[ptr] : {tx[6:0], 1'b0};
            ptr <= bit_cnt[2:0] == 3'd0 ? ptr + ADDR_BITS'(1) : ptr;
            miso_oe <= 1'b1;
            bit_cnt <= bit_cnt + 6'd1;
         end
         if (state == WRITE && sclk_rise) begin
            rx <= rx_nx[6:0];
            bit_cnt <= bit_cnt + 6'd1;
         end
         if (wr_fire) begin
            wr_strobe <= 1'b1;
            wr_addr <= ptr;
            wr_data <= rx_nx;
            ptr <= ptr + ADDR_BITS'(1);
         end
      end
   end
endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder: vector table, directed corner cases and random transactions against a byte-array model
module tb_spi_mem_responder;
   localparam int HALF = 7;
   typedef struct {
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [63:0] wd;
      int          nb;
      int          gap;
      int          ns;
      logic [31:0] rdx;
   } vec_t;
   logic clk = 0, rst = 1, sclk = 0, cs_n = 1, mosi = 0;
   logic miso, miso_oe, busy, wr_strobe;
   logic [7:0] wr_addr, wr_data;
   int nvec = 0, nmis = 0;
   logic [7:0] mm [256];
   bit kn [256];
   logic [15:0] got_st[$], exp_st[$];
   vec_t tbl [12];

   spi_mem_responder dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .busy(busy),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   // system clock
   always #5 clk = ~clk;

   // log every strobed byte; a pulse longer than one clk shows up as a duplicate entry
   always @(negedge clk)
      if (wr_strobe) got_st.push_back({wr_addr, wr_data});

   // watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clk_bit(input logic b, output logic mi, output logic oe, output logic bz);
      mosi = b;
      repeat (HALF) @(negedge clk);
      mi = miso;
      oe = miso_oe;
      bz = busy;
      sclk = 1;
      repeat (HALF) @(negedge clk);
      sclk = 0;
   endtask

   task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input logic [63:0] wd,
                          input int nb, input int gap, output logic [63:0] rd, output int ns);
      logic [95:0] s, oe_v, eoe;
      logic [63:0] erd, msk;
      logic mi, oe, bz, bad;
      int st0, est0, n, a;
      s = {cmd, addr, wd};
      erd = '0; msk = '1; oe_v = '0; eoe = '0; rd = '0; bad = 0;
      st0 = got_st.size();
      est0 = exp_st.size();
      if (nb >= 32 && cmd == 8'h02)
         for (int j = 0; j < (nb - 32) / 8; j++) begin
            a = (int'(addr[7:0]) + j) % 256;
            mm[a] = wd[63 - 8*j -: 8];
            kn[a] = 1;
            exp_st.push_back({8'(a), wd[63 - 8*j -: 8]});
         end
      if (nb >= 32 && cmd == 8'h03)
         for (int k = 32; k < nb; k++) begin
            a = (int'(addr[7:0]) + (k - 32) / 8) % 256;
            erd[95 - k] = mm[a][7 - (k - 32) % 8];
            msk[95 - k] = kn[a];
            eoe[95 - k] = 1;
         end
      cs_n = 0;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < nb; k++) begin
         clk_bit(s[95 - k], mi, oe, bz);
         if (k >= 32) rd[95 - k] = mi;
         oe_v[95 - k] = oe;
         if (!bz || (k < 32 && mi)) bad = 1;
      end
      repeat (HALF) @(negedge clk);
      cs_n = 1;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (!busy) break;
      end
      nvec++;
      if (n < 3 || n > 4) begin
         nmis++;
         $display("FAIL busy_fall: busy low %0d clk after cs_n rise, required 3..4", n);
      end
      repeat (gap - n) @(negedge clk);
      ns = got_st.size() - st0;
      chk("strobe_count", 96'(ns), 96'(exp_st.size() - est0));
      for (int i = 0; i < ns && est0 + i < exp_st.size(); i++)
         chk("strobe_addr_data", 96'(got_st[st0 + i]), 96'(exp_st[est0 + i]));
      chk("miso_oe_pattern", oe_v, eoe);
      chk("read_bits", 96'(rd & msk), 96'(erd & msk));
      chk("busy_hold_hdr_miso", 96'(bad), 96'(0));
   endtask

   initial begin
      logic [63:0] rd, wd;
      logic [95:0] s;
      logic [7:0] cmd;
      logic [23:0] ad;
      logic mi, oe, bz, acc;
      int ns, r, nb;
      tbl[0]  = '{8'h02, 24'h000010, 64'hAABBCCDD_00000000, 64, 20, 4, 32'h0};
      tbl[1]  = '{8'h03, 24'h000010, 64'h0,                 64, 20, 0, 32'hAABBCCDD};
      tbl[2]  = '{8'h02, 24'h000001, 64'h77000000_00000000, 40, 20, 1, 32'h0};
      tbl[3]  = '{8'h02, 24'h0000FF, 64'h11220000_00000000, 48, 20, 2, 32'h0};
      tbl[4]  = '{8'h03, 24'h0000FF, 64'h0,                 56, 20, 0, 32'h11227700};
      tbl[5]  = '{8'h02, 24'h000020, 64'h33000000_00000000, 40, 20, 1, 32'h0};
      tbl[6]  = '{8'h02, 24'h000020, 64'hF8000000_00000000, 37, 20, 0, 32'h0};
      tbl[7]  = '{8'h03, 24'h000020, 64'h0,                 40, 20, 0, 32'h33000000};
      tbl[8]  = '{8'h9F, 24'h000000, 64'h0,                 48, 20, 0, 32'h0};
      tbl[9]  = '{8'h02, 24'h000040, 64'h5A000000_00000000, 40,  8, 1, 32'h0};
      tbl[10] = '{8'h03, 24'h000040, 64'h0,                 40, 20, 0, 32'h5A000000};
      tbl[11] = '{8'h03, 24'hABCD10, 64'h0,                 48, 20, 0, 32'hAABB0000};
      repeat (5) @(negedge clk);
      rst = 0;
      chk("reset_values", 96'({miso, miso_oe, busy, wr_strobe, wr_addr, wr_data}), 96'(0));
      repeat (5) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i].cmd, tbl[i].addr, tbl[i].wd, tbl[i].nb, tbl[i].gap, rd, ns);
         chk("tbl_strobes", 96'(ns), 96'(tbl[i].ns));
         chk("tbl_rdata", 96'(rd[63:32]), 96'(tbl[i].rdx));
      end
      s = {8'h03, 24'h000010, 64'h0};
      cs_n = 0;
      repeat (HALF) @(negedge clk);
      oe = 0;
      for (int k = 0; k < 36; k++) clk_bit(s[95 - k], mi, oe, bz);
      chk("pre_rst_oe", 96'(oe), 96'(1));
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rst_mid_read_outputs", 96'({miso, miso_oe, busy, wr_strobe, wr_addr, wr_data}), 96'(0));
      acc = 0;
      for (int k = 0; k < 16; k++) begin
         clk_bit(1'b1, mi, oe, bz);
         acc = acc | mi | oe | bz;
      end
      chk("post_rst_quiet", 96'(acc), 96'(0));
      cs_n = 1;
      repeat (12) @(negedge clk);
      run_txn(8'h03, 24'h000010, 64'h0, 64, 20, rd, ns);
      chk("read_after_rst", 96'(rd[63:32]), 96'(32'hAABBCCDD));
      for (int t = 0; t < 20; t++) begin
         r = int'($urandom_range(0, 4));
         cmd = r < 2 ? 8'h02 : r < 4 ? 8'h03 : 8'($urandom_range(4, 255));
         ad = 24'($urandom);
         ad[7:0] = 8'($urandom_range(12, 27));
         wd = {32'($urandom), 32'($urandom)};
         nb = int'($urandom_range(20, 96));
         run_txn(cmd, ad, wd, nb, 10 + int'($urandom_range(0, 6)), rd, ns);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
